// File: rtl/stream_range_source.sv
// Arithmetic-sequence stream source: one request emits count beats start, start+step, ...
// on a valid/ready stream, then answers with the modular sum of the emitted beats.
module stream_range_source #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic [N-1:0] start_in,
    input  logic [N-1:0] step_in,
    input  logic [N-1:0] count_in,
    output logic [N-1:0] sum_out,
    output logic [N-1:0] sOut,
    output logic         sOut_valid,
    input  logic         sOut_ready,
    output logic         sOut_last
);

    localparam logic [N-1:0] One = N'(1);
    localparam logic [N-1:0] Two = N'(2);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDone   = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] cur_q, cur_d;
    logic [N-1:0] step_q, step_d;
    logic [N-1:0] rem_q, rem_d;
    logic [N-1:0] sum_q, sum_d;

    logic in_ready_q, in_ready_d;
    logic out_valid_q, out_valid_d;
    logic sout_valid_q, sout_valid_d;
    logic sout_last_q, sout_last_d;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        step_d  = step_q;
        rem_d   = rem_q;
        sum_d   = sum_q;
        sout_last_d = sout_last_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    cur_d       = start_in;
                    step_d      = step_in;
                    rem_d       = count_in;
                    sum_d       = '0;
                    sout_last_d = (count_in == One);
                    state_d     = (count_in != '0) ? StStream : StDone;
                end
            end
            StStream: begin
                // Beat leaves on this edge; last flag tracks the beat that follows it.
                if (sOut_ready) begin
                    cur_d       = cur_q + step_q;
                    sum_d       = sum_q + cur_q;
                    rem_d       = rem_q - One;
                    sout_last_d = (rem_q == Two);
                    if (rem_q == One) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                sout_last_d = 1'b0;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                sout_last_d = 1'b0;
            end
        endcase

        in_ready_d   = (state_d == StIdle);
        out_valid_d  = (state_d == StDone);
        sout_valid_d = (state_d == StStream);
        if (state_d != StStream) begin
            sout_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            cur_q        <= '0;
            step_q       <= '0;
            rem_q        <= '0;
            sum_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            step_q       <= step_d;
            rem_q        <= rem_d;
            sum_q        <= sum_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign sum_out    = sum_q;
    assign sOut       = cur_q;
    assign sOut_valid = sout_valid_q;
    assign sOut_last  = sout_last_q;

endmodule

// File: tb/tb_stream_range_source.sv
// Directed bench for stream_range_source: basic, backpressure, wrap, zero count,
// negative step, response stall with request ignore, and asynchronous reset mid-stream.
module tb_stream_range_source;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] start_in = '0;
    logic [7:0] step_in = '0;
    logic [7:0] count_in = '0;
    logic [7:0] sum_out;
    logic [7:0] sOut;
    logic       sOut_valid;
    logic       sOut_ready = 1'b0;
    logic       sOut_last;

    int checks = 0;
    int failures = 0;

    stream_range_source #(.N(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .start_in   (start_in),
        .step_in    (step_in),
        .count_in   (count_in),
        .sum_out    (sum_out),
        .sOut       (sOut),
        .sOut_valid (sOut_valid),
        .sOut_ready (sOut_ready),
        .sOut_last  (sOut_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake run with sOut_ready and out_ready held high.
    task automatic run_seq(input string tag, input logic [7:0] st, input logic [7:0] sp,
                           input logic [7:0] cnt, input logic [7:0] exp_sum);
        logic [7:0] exp_cur;
        exp_cur    = st;
        sOut_ready = 1'b1;
        out_ready  = 1'b1;
        start_in   = st;
        step_in    = sp;
        count_in   = cnt;
        in_valid   = 1'b1;
        check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < int'(cnt); i++) begin
            check({tag, "_beat_valid"}, 32'(sOut_valid), 32'd1);
            check({tag, "_beat_data"}, 32'(sOut), 32'(exp_cur));
            check({tag, "_beat_last"}, 32'(sOut_last), 32'(i == int'(cnt) - 1));
            exp_cur = exp_cur + sp;
            tick();
        end
        check({tag, "_done_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_done_svalid"}, 32'(sOut_valid), 32'd0);
        check({tag, "_sum"}, 32'(sum_out), 32'(exp_sum));
        tick();
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_ovalid"}, 32'(out_valid), 32'd0);
    endtask

    logic       bp_rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] bp_data [6] = '{8'd5, 8'd7, 8'd7, 8'd7, 8'd9, 8'd9};
    logic       bp_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        #13;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_svalid", 32'(sOut_valid), 32'd0);
        check("rst_sout", 32'(sOut), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_last", 32'(sOut_last), 32'd0);
        nrst = 1'b1;
        tick();

        run_seq("basic", 8'd0, 8'd1, 8'd4, 8'd6);

        // Backpressure with a fixed per-cycle ready pattern.
        start_in = 8'd5; step_in = 8'd2; count_in = 8'd3; in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sOut_ready = bp_rdy[i];
            check("bp_valid", 32'(sOut_valid), 32'd1);
            check("bp_data", 32'(sOut), 32'(bp_data[i]));
            check("bp_last", 32'(sOut_last), 32'(bp_last[i]));
            tick();
        end
        check("bp_done", 32'(out_valid), 32'd1);
        check("bp_sum", 32'(sum_out), 32'd21);
        out_ready = 1'b1;
        tick();
        check("bp_idle", 32'(in_ready), 32'd1);

        run_seq("wrap", 8'd250, 8'd3, 8'd4, 8'd250);
        run_seq("zero", 8'd77, 8'd9, 8'd0, 8'd0);
        run_seq("negstep", 8'd2, 8'd255, 8'd3, 8'd3);

        // Response stall while a new request is held on in_valid.
        start_in = 8'd1; step_in = 8'd1; count_in = 8'd1; in_valid = 1'b1;
        out_ready = 1'b0; sOut_ready = 1'b1;
        tick();
        start_in = 8'd40; step_in = 8'd2; count_in = 8'd2;
        check("stall_beat", 32'(sOut), 32'd1);
        check("stall_beat_last", 32'(sOut_last), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_ovalid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(sum_out), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_svalid", 32'(sOut_valid), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_idle", 32'(in_ready), 32'd1);
        check("stall_idle_svalid", 32'(sOut_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("new_beat0", 32'(sOut), 32'd40);
        check("new_valid0", 32'(sOut_valid), 32'd1);
        tick();
        check("new_beat1", 32'(sOut), 32'd42);
        check("new_last1", 32'(sOut_last), 32'd1);
        tick();
        check("new_sum", 32'(sum_out), 32'd82);
        check("new_done", 32'(out_valid), 32'd1);
        tick();

        // Asynchronous reset after three beats.
        start_in = 8'd10; step_in = 8'd1; count_in = 8'd8; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("pre_rst_beat", 32'(sOut), 32'd13);
        #2 nrst = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_svalid", 32'(sOut_valid), 32'd0);
        check("arst_sout", 32'(sOut), 32'd0);
        check("arst_last", 32'(sOut_last), 32'd0);
        check("arst_ovalid", 32'(out_valid), 32'd0);
        check("arst_sum", 32'(sum_out), 32'd0);
        #10 nrst = 1'b1;
        tick();
        check("post_rst_svalid", 32'(sOut_valid), 32'd0);
        run_seq("fresh", 8'd10, 8'd1, 8'd2, 8'd21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
